// File: rtl/tick_sched.sv
// tick_sched: game-tick scheduler.
// A free-running prescaler produces a 10 kHz strobe (tick_10k).
// While RUN, a game counter divides that strobe down to game_tick.
// The game-tick period is div_reg >> level, and is never less than 1.
// Optional feature macro: TICK_SCHED_AUTO_SPEED_EN.
// When defined, level steps up automatically after every 256 game ticks.
module tick_sched #(
    parameter int BASE_DIV  = 5000,
    parameter int DEF_DIV   = 1000,
    parameter int LEVEL_MAX = 7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        pause,
    input  logic        speed_up,
    input  logic        cfg_valid,
    input  logic [15:0] cfg_div,
    output logic        cfg_ready,
    output logic        tick_10k,
    output logic        game_tick,
    output logic [2:0]  level,
    output logic [1:0]  state
);

    localparam int PW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(BASE_DIV - 1);
    localparam logic [15:0]   DIV_RST    = 16'(DEF_DIV);
    localparam logic [2:0]    LVL_TOP    = 3'(LEVEL_MAX);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    state_t          state_r;
    logic [PW-1:0]   presc_r;
    logic            tick_10k_r;
    logic [15:0]     cnt_r;
    logic [15:0]     div_r;
    logic [2:0]      level_r;
    logic            game_tick_r;
    logic            cfg_ready_r;

    logic [15:0]     shifted_s;
    logic [15:0]     period_s;
    logic [16:0]     cnt_inc_s;
    logic            wrap_s;
    logic            count_en_s;
    logic            load_s;
    logic            level_inc_s;

`ifdef TICK_SCHED_AUTO_SPEED_EN
    logic [7:0]      auto_cnt_r;
`else
    // Auto speed-up is not built; level changes only through speed_up.
`endif

    // Prescaler: wraps every BASE_DIV cycles in every state, strobe is registered.
    always_ff @(posedge clk) begin
        if (!rst) begin
            presc_r    <= '0;
            tick_10k_r <= 1'b0;
        end else begin
            tick_10k_r <= (presc_r == PRESC_LAST);
            if (presc_r == PRESC_LAST) begin
                presc_r <= '0;
            end else begin
                presc_r <= presc_r + PW'(1);
            end
        end
    end

    // Effective period, wrap compare and request qualification.
    always_comb begin
        shifted_s   = div_r >> level_r;
        period_s    = 16'd1;
        cnt_inc_s   = {1'b0, cnt_r} + 17'd1;
        wrap_s      = 1'b0;
        count_en_s  = 1'b0;
        load_s      = 1'b0;
        level_inc_s = 1'b0;

        if (shifted_s == 16'd0) begin
            period_s = 16'd1;
        end else begin
            period_s = shifted_s;
        end

        // >= rather than == so a shrinking period still fires on the next tick.
        if (cnt_inc_s >= {1'b0, period_s}) begin
            wrap_s = 1'b1;
        end else begin
            wrap_s = 1'b0;
        end

        if ((state_r == RUN) && tick_10k_r) begin
            count_en_s = 1'b1;
        end else begin
            count_en_s = 1'b0;
        end

        if (cfg_valid && cfg_ready_r) begin
            load_s = 1'b1;
        end else begin
            load_s = 1'b0;
        end

`ifdef TICK_SCHED_AUTO_SPEED_EN
        if (((state_r == RUN) && speed_up) ||
            (count_en_s && wrap_s && (auto_cnt_r == 8'd255))) begin
            level_inc_s = 1'b1;
        end else begin
            level_inc_s = 1'b0;
        end
`else
        if ((state_r == RUN) && speed_up) begin
            level_inc_s = 1'b1;
        end else begin
            level_inc_s = 1'b0;
        end
`endif
    end

    // Control FSM with game counter, divisor, level and registered strobes.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            cnt_r       <= 16'd0;
            div_r       <= DIV_RST;
            level_r     <= 3'd0;
            game_tick_r <= 1'b0;
            cfg_ready_r <= 1'b1;
`ifdef TICK_SCHED_AUTO_SPEED_EN
            auto_cnt_r  <= 8'd0;
`endif
        end else begin
            game_tick_r <= 1'b0;

            // cfg_ready follows the next state so it is valid in the same cycle as state.
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r     <= RUN;
                        cfg_ready_r <= 1'b0;
                    end else begin
                        state_r     <= IDLE;
                        cfg_ready_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (pause) begin
                        state_r     <= PAUSE;
                        cfg_ready_r <= 1'b1;
                    end else begin
                        state_r     <= RUN;
                        cfg_ready_r <= 1'b0;
                    end
                end
                PAUSE: begin
                    if (!pause) begin
                        state_r     <= RUN;
                        cfg_ready_r <= 1'b0;
                    end else begin
                        state_r     <= PAUSE;
                        cfg_ready_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    cfg_ready_r <= 1'b1;
                end
            endcase

            // A load is only possible outside RUN, so it never races the counter.
            if (load_s) begin
                div_r <= cfg_div;
                cnt_r <= 16'd0;
`ifdef TICK_SCHED_AUTO_SPEED_EN
                auto_cnt_r <= 8'd0;
`endif
            end else if (count_en_s) begin
                if (wrap_s) begin
                    cnt_r       <= 16'd0;
                    game_tick_r <= 1'b1;
`ifdef TICK_SCHED_AUTO_SPEED_EN
                    auto_cnt_r  <= auto_cnt_r + 8'd1;
`endif
                end else begin
                    cnt_r <= cnt_inc_s[15:0];
                end
            end else begin
                cnt_r <= cnt_r;
            end

            if (level_inc_s && (level_r < LVL_TOP)) begin
                level_r <= level_r + 3'd1;
            end else begin
                level_r <= level_r;
            end
        end
    end

    assign cfg_ready = cfg_ready_r;
    assign tick_10k  = tick_10k_r;
    assign game_tick = game_tick_r;
    assign level     = level_r;
    assign state     = state_r;

endmodule
